// File: rtl/functiongen_pkg.sv
// Shared types, constants and helpers for the binary-to-BCD converter.
`timescale 1ns/1ps
package functiongen_pkg;

    // Converter FSM: idle waiting for a value, or shifting one bit per clock
    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } conv_state_e;

    // Bits per packed BCD digit
    localparam int BCD_DIGIT_W = 4;

    // Largest value representable in `digits` decimal digits (10^digits - 1)
    function automatic logic [63:0] max_val(input int digits);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
`timescale 1ns/1ps
module bcd_digit_adj
    import functiongen_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] dig_i,
    output logic [BCD_DIGIT_W-1:0] dig_o
);

    // Pure combinational add-3-if-at-least-5
    always_comb begin
        dig_o = dig_i;
        if (dig_i >= BCD_DIGIT_W'(5)) begin
            dig_o = dig_i + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one binary bit per clock, inputs above
// the display's full scale saturate to all-9s with an overflow flag. Results
// are held in dedicated output registers so the display never sees the
// scratch register mid-conversion.
`timescale 1ns/1ps
module bin_to_bcd_seq
    import functiongen_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      in_bin,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic                  done
);

    localparam int                SCR_W    = BCD_DIGIT_W * DIGITS;
    localparam int                CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [63:0]       MAX_VAL  = max_val(DIGITS);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BIN_W - 1);

    conv_state_e                          state_q;
    logic [CNT_W-1:0]                     cnt_q;
    logic [BIN_W-1:0]                     bin_q;
    logic [DIGITS-1:0][BCD_DIGIT_W-1:0]   scr_q;
    logic                                 pend_ovf_q;
    logic [DIGITS-1:0][BCD_DIGIT_W-1:0]   bcd_q;
    logic                                 ovf_q;
    logic                                 done_q;
    logic                                 rdy_q;

    logic [DIGITS-1:0][BCD_DIGIT_W-1:0]   scr_adj;
    logic [DIGITS-1:0][BCD_DIGIT_W-1:0]   scr_d;
    logic [BIN_W-1:0]                     bin_d;
    logic [SCR_W+BIN_W-1:0]               cat_sh;
    logic                                 in_over;
    logic [BIN_W-1:0]                     in_load;

    // Per-digit add-3 correction applied before every shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .dig_i (scr_q[g]),
            .dig_o (scr_adj[g])
        );
    end

    // Next scratch/binary values: shift {adjusted scratch, binary} left by one.
    // The scratch MSB dropped here is always zero because inputs saturate.
    always_comb begin
        cat_sh = {scr_adj, bin_q} << 1;
        scr_d  = cat_sh[SCR_W+BIN_W-1:BIN_W];
        bin_d  = cat_sh[BIN_W-1:0];
    end

    // Input saturation: clamp anything above full scale and remember it
    always_comb begin
        in_over = (64'(in_bin) > MAX_VAL);
        in_load = in_over ? BIN_W'(MAX_VAL) : in_bin;
    end

    // Converter FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bin_q      <= '0;
            scr_q      <= '0;
            pend_ovf_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid && rdy_q) begin
                        bin_q      <= in_load;
                        scr_q      <= '0;
                        cnt_q      <= '0;
                        pend_ovf_q <= in_over;
                        rdy_q      <= 1'b0;
                        state_q    <= CONV;
                    end
                end
                CONV: begin
                    scr_q <= scr_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        // Final shift: publish the result and reopen the input
                        bcd_q   <= scr_d;
                        ovf_q   <= pend_ovf_q;
                        done_q  <= 1'b1;
                        rdy_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready = rdy_q;
    assign bcd      = bcd_q;
    assign ovf      = ovf_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: the driver pushes expected results at
// each accept, a negedge monitor pops and checks them on every done pulse and
// also checks latency, the busy window, done width and output hold.
`timescale 1ns/1ps
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          t;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [13:0] in_bin;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bcd;
    logic        ovf;
    logic        done;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    logic [15:0] prev_bcd = '0;
    logic        prev_ovf = 1'b0;
    logic        prev_done = 1'b0;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst_n),
        .in_bin   (in_bin),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bcd      (bcd),
        .ovf      (ovf),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Decimal reference with saturation to 9999
    function automatic logic [15:0] ref_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    // Present a value, wait (bounded) for the accept, record the expectation
    task automatic send(input logic [13:0] v, input logic [15:0] eb, input logic eo, output int t);
        int w;
        w = 0;
        in_bin   = v;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("accept_timeout", 32'(in_ready), 32'd1);
        if (in_ready) begin
            t = cyc + 1;
            sb.push_back('{bcd: eb, ovf: eo, t: t});
        end else begin
            t = -1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: result checks on done, busy window and hold checks otherwise
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_bcd  = bcd;
            prev_ovf  = ovf;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                chk("done_width", 32'(prev_done), 32'd0);
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("bcd", 32'(bcd), 32'(e.bcd));
                    chk("ovf", 32'(ovf), 32'(e.ovf));
                    chk("latency", 32'(cyc), 32'(e.t + BIN_W));
                    chk("ready_at_done", 32'(in_ready), 32'd1);
                end
            end else begin
                chk("hold_bcd", 32'(bcd), 32'(prev_bcd));
                chk("hold_ovf", 32'(ovf), 32'(prev_ovf));
                if (sb.size() > 0) begin
                    if (cyc >= sb[0].t && cyc < sb[0].t + BIN_W) begin
                        chk("busy_ready", 32'(in_ready), 32'd0);
                    end else if (cyc >= sb[0].t + BIN_W) begin
                        chk("done_missing", 32'(done), 32'd1);
                        void'(sb.pop_front());
                    end
                end
            end
            prev_bcd  = bcd;
            prev_ovf  = ovf;
            prev_done = done;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [13:0] dir_in  [4] = '{14'd1234, 14'd9999, 14'd12000, 14'd0};
    logic [15:0] dir_bcd [4] = '{16'h1234, 16'h9999, 16'h9999, 16'h0000};
    logic        dir_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int t, t1, t2;
        logic [13:0] v;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_bin   = '0;

        // Reset state, checked while held and after release
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_bcd", 32'(bcd), 32'h0);
        @(posedge clk);
        #1;

        // Directed values: nominal, full scale, saturation, zero
        for (int i = 0; i < 4; i++) begin
            send(dir_in[i], dir_bcd[i], dir_ovf[i], t);
            in_valid = 1'b0;
            wait_idle();
            repeat (2) @(posedge clk);
            #1;
        end

        // Held valid, back-to-back accepts
        send(14'd42, 16'h0042, 1'b0, t1);
        send(14'd7001, 16'h7001, 1'b0, t2);
        in_valid = 1'b0;
        chk("b2b_gap", 32'(t2 - t1), 32'd15);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-conversion
        send(14'd5678, 16'h5678, 1'b0, t);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b0;
        #1;
        chk("abort_bcd", 32'(bcd), 32'h0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_hold_bcd", 32'(bcd), 32'h0);
        @(posedge clk);
        #1;
        send(14'd5678, 16'h5678, 1'b0, t);
        in_valid = 1'b0;
        wait_idle();

        // Random values with random valid gaps against the decimal model
        for (int i = 0; i < 1000; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            if ($urandom_range(0, 1) == 1)
                v = 14'($urandom_range(0, 9999));
            else
                v = 14'($urandom_range(0, 16383));
            send(v, ref_bcd(int'(v)), (v > 14'd9999), t);
        end
        in_valid = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
